// File: rtl/crd_pool_scheduler.sv
// crd_pool_scheduler: shared link-layer credit pool with round-robin grants to NUM_REQ consumers.
// Optional macro CRD_RESERVE_EN holds RESERVE_CRD credits back for requester 0.
module crd_pool_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int CRD_WIDTH   = 7,
    parameter int COST_WIDTH  = 3,
    parameter int RESERVE_CRD = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_init_vld,
    input  logic [CRD_WIDTH-1:0]          i_init_val,
    input  logic                          i_hold,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*COST_WIDTH-1:0] i_req_cost,
    input  logic                          i_ret_en,
    input  logic [CRD_WIDTH-1:0]          i_ret_val,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [$clog2(NUM_REQ)-1:0]    o_gnt_id,
    output logic [CRD_WIDTH-1:0]          o_credits,
    output logic                          o_empty,
    output logic                          o_ret_ovf,
    output logic                          o_active
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_HOLD      = 2'd2
    } state_e;

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [CRD_WIDTH-1:0]   pool_r;
    logic [CRD_WIDTH-1:0]   pool_nxt_s;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [NUM_REQ-1:0]     gnt_r;
    logic [ID_W-1:0]        gnt_id_r;
    logic                   ret_ovf_r;

    logic                   fsm_active_s;
    logic                   gnt_allow_s;
    logic                   ret_allow_s;
    logic [CRD_WIDTH-1:0]   cost_ext_s [NUM_REQ];
    logic [NUM_REQ-1:0]     rsv_ok_s;
    logic [NUM_REQ-1:0]     elig_s;
    logic                   win_found_s;
    logic [ID_W-1:0]        win_id_s;
    logic                   gnt_go_s;
    logic [CRD_WIDTH-1:0]   ret_add_s;
    logic [CRD_WIDTH:0]     sum_wide_s;
    logic [CRD_WIDTH-1:0]   sum_s;
    logic                   ovf_set_s;

    // Modular index add used for the rotating search and the pointer advance.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input logic [ID_W-1:0] off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_WAIT_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a pool reload freezes ACTIVE/HOLD.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT_INIT: begin
                if (i_init_vld) state_nxt_s = ST_ACTIVE;
                else            state_nxt_s = ST_WAIT_INIT;
            end
            ST_ACTIVE: begin
                if (i_hold && !i_init_vld) state_nxt_s = ST_HOLD;
                else                       state_nxt_s = ST_ACTIVE;
            end
            ST_HOLD: begin
                if (!i_hold && !i_init_vld) state_nxt_s = ST_ACTIVE;
                else                        state_nxt_s = ST_HOLD;
            end
            default: state_nxt_s = ST_WAIT_INIT;
        endcase
    end

    // FSM outputs: which state may grant and which may absorb returns.
    always_comb begin
        fsm_active_s = 1'b0;
        gnt_allow_s  = 1'b0;
        ret_allow_s  = 1'b0;
        case (state_r)
            ST_ACTIVE: begin
                fsm_active_s = 1'b1;
                gnt_allow_s  = !i_hold && !i_init_vld;
                ret_allow_s  = !i_init_vld;
            end
            ST_HOLD: begin
                ret_allow_s  = !i_init_vld;
            end
            default: begin
                fsm_active_s = 1'b0;
            end
        endcase
    end

    // Unpack per-requester costs, widened to the pool width.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cost_ext_s[k] = CRD_WIDTH'(i_req_cost[k*COST_WIDTH +: COST_WIDTH]);
        end
    end

`ifdef CRD_RESERVE_EN
    // Requester 0 may drain the pool; the others must leave RESERVE_CRD behind.
    always_comb begin
        rsv_ok_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k == 0) begin
                rsv_ok_s[k] = 1'b1;
            end else if ((cost_ext_s[k] <= pool_r) &&
                         ((pool_r - cost_ext_s[k]) >= CRD_WIDTH'(RESERVE_CRD))) begin
                rsv_ok_s[k] = 1'b1;
            end else begin
                rsv_ok_s[k] = 1'b0;
            end
        end
    end
`else
    logic [31:0] unused_reserve_s;
    assign unused_reserve_s = 32'(RESERVE_CRD);
    assign rsv_ok_s         = '1;
`endif

    // Eligibility from the registered pool; the requester whose grant is visible is masked.
    always_comb begin
        elig_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req[k] && !gnt_r[k] && rsv_ok_s[k] &&
                (cost_ext_s[k] != '0) && (cost_ext_s[k] <= pool_r)) begin
                elig_s[k] = 1'b1;
            end else begin
                elig_s[k] = 1'b0;
            end
        end
    end

    // Rotating search for the first eligible requester at or after the rr pointer.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found_s && elig_s[wrap_idx(rr_ptr_r, ID_W'(i))]) begin
                win_found_s = 1'b1;
                win_id_s    = wrap_idx(rr_ptr_r, ID_W'(i));
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign gnt_go_s = gnt_allow_s && win_found_s;

    // Pool update: saturating return first, then the winner's cost.
    always_comb begin
        ret_add_s  = i_ret_en ? i_ret_val : '0;
        sum_wide_s = {1'b0, pool_r} + {1'b0, ret_add_s};
        sum_s      = sum_wide_s[CRD_WIDTH] ? {CRD_WIDTH{1'b1}} : sum_wide_s[CRD_WIDTH-1:0];
        ovf_set_s  = ret_allow_s && sum_wide_s[CRD_WIDTH];
        if (i_init_vld) begin
            pool_nxt_s = i_init_val;
        end else if (ret_allow_s) begin
            pool_nxt_s = sum_s - (gnt_go_s ? cost_ext_s[win_id_s] : '0);
        end else begin
            pool_nxt_s = pool_r;
        end
    end

    // Datapath registers: pool, overflow flag, grant outputs and rr pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pool_r    <= '0;
            ret_ovf_r <= 1'b0;
            gnt_r     <= '0;
            gnt_id_r  <= '0;
            rr_ptr_r  <= '0;
        end else begin
            pool_r    <= pool_nxt_s;
            ret_ovf_r <= ret_ovf_r | ovf_set_s;
            if (gnt_go_s) begin
                gnt_r    <= NUM_REQ'(1) << win_id_s;
                gnt_id_r <= win_id_s;
                rr_ptr_r <= wrap_idx(win_id_s, ID_W'(1));
            end else begin
                gnt_r    <= '0;
                gnt_id_r <= gnt_id_r;
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign o_gnt     = gnt_r;
    assign o_gnt_id  = gnt_id_r;
    assign o_credits = pool_r;
    assign o_empty   = (pool_r == '0);
    assign o_ret_ovf = ret_ovf_r;
    assign o_active  = fsm_active_s;

endmodule

// File: tb/tb_crd_pool_scheduler.sv
// Directed bench for crd_pool_scheduler: hand-computed grant order, pool values and flags.
module tb_crd_pool_scheduler;

    logic        i_clk;
    logic        i_rst;
    logic        i_init_vld;
    logic [6:0]  i_init_val;
    logic        i_hold;
    logic [3:0]  i_req;
    logic [11:0] i_req_cost;
    logic        i_ret_en;
    logic [6:0]  i_ret_val;
    logic [3:0]  o_gnt;
    logic [1:0]  o_gnt_id;
    logic [6:0]  o_credits;
    logic        o_empty;
    logic        o_ret_ovf;
    logic        o_active;

    int total = 0;
    int bad   = 0;

    crd_pool_scheduler #(
        .NUM_REQ     (4),
        .CRD_WIDTH   (7),
        .COST_WIDTH  (3),
        .RESERVE_CRD (8)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_init_vld (i_init_vld),
        .i_init_val (i_init_val),
        .i_hold     (i_hold),
        .i_req      (i_req),
        .i_req_cost (i_req_cost),
        .i_ret_en   (i_ret_en),
        .i_ret_val  (i_ret_val),
        .o_gnt      (o_gnt),
        .o_gnt_id   (o_gnt_id),
        .o_credits  (o_credits),
        .o_empty    (o_empty),
        .o_ret_ovf  (o_ret_ovf),
        .o_active   (o_active)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [11:0] costs(input int c0, input int c1, input int c2, input int c3);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant vector, pool, empty flag and active flag; grant id only when a grant is expected.
    task automatic check_out(input string tag, input logic [3:0] gnt, input logic [1:0] id,
                             input logic [6:0] cr, input logic act);
        check({tag, ".gnt"}, 32'(o_gnt), 32'(gnt));
        if (gnt != 4'd0) check({tag, ".id"}, 32'(o_gnt_id), 32'(id));
        check({tag, ".credits"}, 32'(o_credits), 32'(cr));
        check({tag, ".empty"}, 32'(o_empty), 32'(cr == 7'd0));
        check({tag, ".active"}, 32'(o_active), 32'(act));
    endtask

    initial begin
        logic [3:0] rr_gnt [5];
        logic [1:0] rr_id  [5];
        logic [6:0] rr_cr  [5];
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_cr  = '{7'd18, 7'd16, 7'd14, 7'd12, 7'd10};

        i_rst = 1'b1; i_init_vld = 1'b0; i_init_val = 7'd0; i_hold = 1'b0;
        i_req = 4'b0000; i_req_cost = costs(2, 2, 2, 2); i_ret_en = 1'b0; i_ret_val = 7'd0;
        tick();
        check_out("reset", 4'b0000, 2'd0, 7'd0, 1'b0);
        check("reset.id", 32'(o_gnt_id), 32'd0);
        check("reset.ovf", 32'(o_ret_ovf), 32'd0);

        // WAIT_INIT ignores requests and returns
        i_rst = 1'b0; i_req = 4'b1111; i_ret_en = 1'b1; i_ret_val = 7'd5;
        tick();
        check_out("wait_init", 4'b0000, 2'd0, 7'd0, 1'b0);

        // init load overrides same-cycle return
        i_init_vld = 1'b1; i_init_val = 7'd20;
        tick();
        check_out("init", 4'b0000, 2'd0, 7'd20, 1'b1);

        // round robin with continuous requests, cost 2
        i_init_vld = 1'b0; i_ret_en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check_out($sformatf("rr%0d", n), rr_gnt[n], rr_id[n], rr_cr[n], 1'b1);
        end

        // hold for 3 cycles with returns of 1
        i_hold = 1'b1; i_ret_en = 1'b1; i_ret_val = 7'd1;
        tick(); check_out("hold0", 4'b0000, 2'd0, 7'd11, 1'b0);
        tick(); check_out("hold1", 4'b0000, 2'd0, 7'd12, 1'b0);
        tick(); check_out("hold2", 4'b0000, 2'd0, 7'd13, 1'b0);
        i_hold = 1'b0; i_ret_en = 1'b0;
        tick(); check_out("unhold", 4'b0000, 2'd0, 7'd13, 1'b1);
        tick(); check_out("resume", 4'b0010, 2'd1, 7'd11, 1'b1);

        // grant to 0 moves pointer to 1
        i_req = 4'b0001; i_req_cost = costs(1, 2, 2, 2);
        tick(); check_out("ptr_set", 4'b0001, 2'd0, 7'd10, 1'b1);

        // reload in ACTIVE discards grant and return
        i_req = 4'b1111; i_req_cost = costs(2, 2, 2, 2);
        i_init_vld = 1'b1; i_init_val = 7'd3; i_ret_en = 1'b1; i_ret_val = 7'd7;
        tick(); check_out("reload", 4'b0000, 2'd0, 7'd3, 1'b1);

        // no head-of-line blocking: req1 cost 5 skipped, req2 cost 2 granted
        i_init_vld = 1'b0; i_ret_en = 1'b0;
        i_req = 4'b0110; i_req_cost = costs(1, 5, 2, 2);
        tick(); check_out("no_hol", 4'b0100, 2'd2, 7'd1, 1'b1);

        // return of 4 does not count toward same-cycle eligibility
        i_req = 4'b0010; i_ret_en = 1'b1; i_ret_val = 7'd4;
        tick(); check_out("ret_late", 4'b0000, 2'd0, 7'd5, 1'b1);
        i_ret_en = 1'b0;
        tick(); check_out("req1_gnt", 4'b0010, 2'd1, 7'd0, 1'b1);

        // refill, then back-to-back block on a stale request
        i_req = 4'b0000; i_ret_en = 1'b1; i_ret_val = 7'd20;
        tick(); check_out("refill", 4'b0000, 2'd0, 7'd20, 1'b1);
        i_ret_en = 1'b0; i_req = 4'b0001; i_req_cost = costs(1, 2, 2, 2);
        tick(); check_out("b2b_a", 4'b0001, 2'd0, 7'd19, 1'b1);
        tick(); check_out("b2b_blk", 4'b0000, 2'd0, 7'd19, 1'b1);
        tick(); check_out("b2b_b", 4'b0001, 2'd0, 7'd18, 1'b1);

        // cost 0 is ineligible
        i_req = 4'b0000;
        tick(); check_out("idle", 4'b0000, 2'd0, 7'd18, 1'b1);
        i_req = 4'b0001; i_req_cost = costs(0, 2, 2, 2);
        tick(); check_out("cost0", 4'b0000, 2'd0, 7'd18, 1'b1);

        // saturation with simultaneous cost-3 grant: 120+10 -> 127 - 3 = 124
        i_req = 4'b0000; i_init_vld = 1'b1; i_init_val = 7'd120;
        tick(); check_out("load120", 4'b0000, 2'd0, 7'd120, 1'b1);
        check("pre_ovf", 32'(o_ret_ovf), 32'd0);
        i_init_vld = 1'b0; i_req = 4'b1000; i_req_cost = costs(2, 2, 2, 3);
        i_ret_en = 1'b1; i_ret_val = 7'd10;
        tick(); check_out("sat", 4'b1000, 2'd3, 7'd124, 1'b1);
        check("sat.ovf", 32'(o_ret_ovf), 32'd1);
        i_req = 4'b0000; i_ret_en = 1'b0;
        tick(); check("ovf_sticky", 32'(o_ret_ovf), 32'd1);
        i_init_vld = 1'b1; i_init_val = 7'd20;
        tick(); check_out("load20", 4'b0000, 2'd0, 7'd20, 1'b1);
        check("ovf_after_load", 32'(o_ret_ovf), 32'd1);

        // reservation scenario: pointer to 1, pool 10, req0/req1 cost 3
        i_init_vld = 1'b0; i_req = 4'b0001; i_req_cost = costs(1, 2, 2, 2);
        tick(); check_out("ptr1", 4'b0001, 2'd0, 7'd19, 1'b1);
        i_req = 4'b0000; i_init_vld = 1'b1; i_init_val = 7'd10;
        tick(); check_out("load10", 4'b0000, 2'd0, 7'd10, 1'b1);
        i_init_vld = 1'b0; i_req = 4'b0011; i_req_cost = costs(3, 3, 2, 2);
        tick();
`ifdef CRD_RESERVE_EN
        check_out("reserve", 4'b0001, 2'd0, 7'd7, 1'b1);
`else
        check_out("reserve", 4'b0010, 2'd1, 7'd7, 1'b1);
`endif

        // reset mid-operation aborts everything
        i_rst = 1'b1;
        tick(); check_out("mid_rst", 4'b0000, 2'd0, 7'd0, 1'b0);
        check("mid_rst.id", 32'(o_gnt_id), 32'd0);
        check("mid_rst.ovf", 32'(o_ret_ovf), 32'd0);
        i_rst = 1'b0;
        tick(); check_out("post_rst", 4'b0000, 2'd0, 7'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crd_pool_scheduler.md
Name: crd_pool_scheduler

Overview:
- Link-layer credit scheduler for the CXL controller. It owns one shared credit pool: a saturating up/down counter register of CRD_WIDTH bits.
- It arbitrates NUM_REQ requesters that consume credits, using round-robin order, and absorbs credit returns from the remote agent.
- It sits between the TX flit-pack requesters and the credit-return decode path, and gates transmission when credits run out.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CRD_WIDTH, 7, pool counter width; maximum pool value is 2^CRD_WIDTH-1.
- COST_WIDTH, 3, width of each requester's credit cost (cost 1..7; cost 0 is illegal).
- RESERVE_CRD, 8, credits held back for requester 0 (used only with CRD_RESERVE_EN).

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_init_vld, input, 1, load of the initial credit count advertised by the peer.
- i_init_val, input, CRD_WIDTH, initial credit value.
- i_hold, input, 1, suspend grants (retry/replay in progress).
- i_req, input, NUM_REQ, per-requester request level.
- i_req_cost, input, NUM_REQ*COST_WIDTH, packed cost; requester k occupies bits [k*COST_WIDTH +: COST_WIDTH].
- i_ret_en, input, 1, credit return strobe.
- i_ret_val, input, CRD_WIDTH, number of credits returned.
- o_gnt, output, NUM_REQ, one-hot grant pulse.
- o_gnt_id, output, $clog2(NUM_REQ), index of the granted requester; valid when o_gnt is non-zero.
- o_credits, output, CRD_WIDTH, current pool value.
- o_empty, output, 1, o_credits == 0.
- o_ret_ovf, output, 1, sticky flag: a return saturated the pool.
- o_active, output, 1, FSM is in ACTIVE.

Behaviour:
- Reset (i_rst high at a clock edge) sets: state WAIT_INIT, pool 0, rr pointer 0, o_gnt 0, o_gnt_id 0, o_ret_ovf 0, o_active 0. o_empty then reads 1.
- Reset mid-operation aborts everything; no grant is issued in the cycle after reset.
- FSM states: WAIT_INIT, ACTIVE, HOLD.
  - WAIT_INIT -> ACTIVE on i_init_vld. The pool loads i_init_val, and that load overrides any i_ret_en in the same cycle.
  - ACTIVE -> HOLD when i_hold=1. HOLD -> ACTIVE when i_hold=0.
  - i_init_vld in ACTIVE or HOLD reloads the pool with i_init_val. Any grant and return in that cycle are discarded. The state does not change.
- Grants are issued only in ACTIVE with i_hold=0. In WAIT_INIT and HOLD, o_gnt=0. Returns still accumulate in HOLD; they are ignored in WAIT_INIT.
- Eligibility: requester k is eligible when i_req[k]=1 and cost_k <= pool. Eligibility uses the registered pool only; a same-cycle return does not count toward eligibility.
- Arbitration: the first eligible requester searching from the rr pointer upward, with wrap-around.
  - The rr pointer moves to (winner+1) mod NUM_REQ on a grant. It is unchanged when there is no grant.
  - An ineligible higher-priority requester does not block eligible ones; no head-of-line blocking.
- Output timing: o_gnt and o_gnt_id are registered, asserted in the cycle after the decision, for exactly one cycle.
  - The requester sees the grant one cycle later. It must drop or refresh i_req in that cycle.
  - The scheduler blocks a back-to-back grant to the same requester in the cycle its previous grant is visible, to avoid a double grant from a stale request.
- Pool update each cycle: sum = sat(pool + (i_ret_en ? i_ret_val : 0)); next pool = sum - (grant ? cost_winner : 0).
  - Saturation: if the addition overflows CRD_WIDTH bits, the sum clamps to all ones and o_ret_ovf sets.
  - o_ret_ovf clears only on reset.
  - Subtraction never underflows, because eligibility guarantees cost <= pool <= sum.
- Simultaneous return and grant are both applied in the same cycle, per the formula above.
- A cost of 0 is treated as ineligible.
- o_credits and o_empty reflect the registered pool with zero latency. o_active = (state == ACTIVE).

Optional Feature:
- Macro: CRD_RESERVE_EN.
- Defined:
  - Requester k != 0 is eligible only if pool - cost_k >= RESERVE_CRD.
  - Requester 0 (retry/control traffic) may use the whole pool.
  - Round-robin order is otherwise unchanged.
- Undefined: no reservation, and the RESERVE_CRD parameter is unused.

Test Plan:
- Reset, then i_init_vld with i_init_val=20 -> o_active=1 next cycle, o_credits=20, o_gnt=0 throughout WAIT_INIT.
- Pool=20; requesters 0..3 all requesting, cost 2 each, held continuously -> grants follow order 0,1,2,3,0 in successive grant cycles; o_credits decreases by 2 per grant.
- Pool=3; req1 cost 5, req2 cost 2, rr pointer=1 -> req2 is granted and pool=1; req1 is not granted until a return of 4 arrives (pool=5).
- Pool=120; i_ret_en with i_ret_val=10 at the same time as a cost-3 grant -> sum saturates at 127, o_ret_ovf=1, pool=124.
- ACTIVE with pool=10, assert i_hold for 3 cycles with returns of 1 per cycle -> no o_gnt pulses, pool=13, then grants resume after i_hold drops.
- CRD_RESERVE_EN, RESERVE_CRD=8, pool=10; req1 cost 3 and req0 cost 3 both requesting, rr pointer=1 -> req1 is blocked (10-3<8) and req0 is granted, leaving pool=7.
